load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  async active-low reset.
- addr_E  in  32  effective byte address.
- rs2_E  in  32  store source.
- funct3_E  in  3  access size/sign.
- rd_en  in  1  load request.
- wr_en  in  1  store request.
- data_rd  in  32  word from data memory.
- uart_tx_ready  in  1  transmitter accepts byte.
- addrL_LSU  out  32  load word index.
- addrS_LSU  out  32  store word index.
- store  out  32  lane-replicated store data.
- mask  out  4  byte-lane enables.
- cs_E  out  1  data memory select, active-low.
- wr_E  out  1  data memory write.
- Data_Memory_on  out  1  data memory region hit.
- load_data  out  32  extended load result.
- stall  out  1  freeze pipeline.
- uart_tx_data  out  8  FIFO head byte.
- uart_tx_valid  out  1  FIFO non-empty.
- access_fault  out  1  sticky fault flag.
REQ-003 SHALL have parameters (name, default, meaning):
- TX_DEPTH  4  UART TX FIFO entries.
- UART_BASE  32'h8000_0000  UART register base.

Function
REQ-004 SHALL decode the address as follows:
- data memory: addr_E[31:10]==0; word index = {24'b0, addr_E[9:2]}, driven on both addrL_LSU and addrS_LSU.
- TXDATA register: UART_BASE.
- STATUS register: UART_BASE+4.
- anything else is unmapped.
REQ-005 SHALL use funct3 encodings 000 B, 001 H, 010 W, 100 BU, 101 HU; any other funct3 on an access is a fault.
REQ-006 SHALL treat a halfword access with addr_E[0]=1, or a word access with addr_E[1:0]!=0, as misaligned: no memory access and no FIFO push.
REQ-007 SHALL drive the data memory signals combinationally, only for an aligned data memory access: Data_Memory_on=1, cs_E=0, wr_E=wr_en; otherwise Data_Memory_on=0, cs_E=1, wr_E=0.
REQ-008 SHALL form store and mask as follows:
- SB: store={4{rs2[7:0]}}, mask=1<<addr_E[1:0].
- SH: store={2{rs2[15:0]}}, mask=addr_E[1] ? 1100 : 0011.
- SW: store=rs2, mask=1111.
- mask=0000 when there is no valid store.
REQ-009 SHALL select the load byte or half by addr_E[1:0], then sign-extend (B, H) or zero-extend (BU, HU); W passes through unchanged; latency is zero (combinational).
REQ-010 SHALL return on a STATUS load: {27'b0, count[2:0], empty, full}.
REQ-011 SHALL return load_data=0 on unmapped, misaligned, or TXDATA loads.
REQ-012 SHALL push rs2[7:0] into the FIFO on a TXDATA store with funct3=000 when the FIFO is not full; any other store size to TXDATA is a fault.
REQ-013 SHALL handle a TXDATA store while the FIFO is full as follows:
- stall=1 combinationally, with no push.
- This holds even if a pop happens in the same cycle; the push then completes on the first cycle the FIFO is not full.
REQ-014 SHALL drive uart_tx_valid=!empty and uart_tx_data=head, and SHALL pop on a rising edge when uart_tx_valid && uart_tx_ready.
REQ-015 SHALL apply a simultaneous push and pop on a non-full FIFO in the same edge: count unchanged, head advances.
REQ-016 SHALL wrap the FIFO read and write pointers modulo TX_DEPTH.
REQ-017 SHALL set access_fault on the edge after any misaligned, unmapped, or illegal-funct3 request, and it SHALL stay set until reset.
REQ-018 SHALL have stall=0 whenever no TXDATA store is requested.

Reset
REQ-019 SHALL, on reset=0, asynchronously clear the FIFO pointers and count and clear access_fault; uart_tx_valid=0 and stall=0 follow.
REQ-020 SHALL discard FIFO contents on a reset mid-transfer, and no byte SHALL be presented until a new push.

Structure
REQ-021 SHALL place in package lsu_pkg: the funct3 enum, the UART_BASE/STATUS offsets, the data memory region limit, and the status bit positions.
REQ-022 SHALL implement the FIFO as sub-module uart_tx_fifo (parameter TX_DEPTH; push, pop, full, empty, count), instantiated once.

Verification
REQ-023 SHALL cover: SH rs2=32'h0000_BEEF to addr 0x0000_0006 -> addrS_LSU=1, store=32'hBEEF_BEEF, mask=1100, cs_E=0, wr_E=1.
REQ-024 SHALL cover: LB at addr 0x0000_0003 with data_rd=32'h80_11_22_33 -> load_data=32'hFFFF_FF80; LBU -> 32'h0000_0080.
REQ-025 SHALL cover: five SB to TXDATA with uart_tx_ready=0 -> after four pushes, count=4 and the fifth store gives stall=1; with ready=1 for one cycle -> the 0x41 pop completes, stall drops the next cycle, and the fifth byte is pushed.
REQ-026 SHALL cover: LW at addr 0x0000_0002 -> cs_E=1, load_data=0, access_fault=1 the next cycle and held until reset.
REQ-027 SHALL cover: reset asserted with count=3 -> uart_tx_valid=0 immediately; STATUS load after release returns 32'h0000_0002.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: access-size encoding,
//            UART register map, data-memory region limit and the bit layout
//            of the UART STATUS register.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Access size / signedness carried in funct3.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // UART register map, relative to the UART base address.
    localparam logic [31:0] C_UART_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] C_UART_TXDATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] C_UART_STATUS_OFS   = 32'h0000_0004;

    // Data memory occupies [0, 2**C_DMEM_ADDR_BITS): all higher bits must be 0.
    localparam int C_DMEM_ADDR_BITS = 10;

    // STATUS register layout: {27'b0, count[2:0], empty, full}.
    localparam int C_STAT_FULL_BIT  = 0;
    localparam int C_STAT_EMPTY_BIT = 1;
    localparam int C_STAT_COUNT_LSB = 2;
    localparam int C_STAT_COUNT_W   = 3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO feeding the UART transmitter. Pointers wrap modulo
//            TX_DEPTH, so non-power-of-two depths are supported.
// Ports    : clk, reset (async, active-low)
//            push/push_data : enqueue (ignored when full)
//            pop            : dequeue (ignored when empty)
//            head           : oldest byte
//            full/empty/count : occupancy
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int TX_DEPTH = 4,
    localparam int CNT_W   = $clog2(TX_DEPTH + 1),
    localparam int PTR_W   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [7:0]       mem_q [0:TX_DEPTH-1];

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TX_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full      = (count_q == CNT_W'(TX_DEPTH));
        empty     = (count_q == '0);
        count     = count_q;
        head      = mem_q[rd_ptr_q];
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;

        wr_ptr_d  = w_do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = w_do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: stale bytes are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Decodes execute-stage loads/stores into data-memory accesses or
//            UART TX register accesses, builds store lanes/masks, extends
//            load data, and raises a sticky fault on bad requests.
// Ports    : clk, reset (async, active-low)
//            addr_E/rs2_E/funct3_E/rd_en/wr_en : request from execute stage
//            data_rd                           : word read from data memory
//            addrL_LSU/addrS_LSU/store/mask/cs_E/wr_E/Data_Memory_on : memory
//            load_data                         : extended load result
//            stall                             : TXDATA store blocked by full FIFO
//            uart_tx_data/valid/ready          : transmitter handshake
//            access_fault                      : sticky fault flag
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          TX_DEPTH  = 4,
    parameter logic [31:0] UART_BASE = C_UART_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_E,
    input  logic [31:0] rs2_E,
    input  logic [2:0]  funct3_E,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] data_rd,
    input  logic        uart_tx_ready,
    output logic [31:0] addrL_LSU,
    output logic [31:0] addrS_LSU,
    output logic [31:0] store,
    output logic [3:0]  mask,
    output logic        cs_E,
    output logic        wr_E,
    output logic        Data_Memory_on,
    output logic [31:0] load_data,
    output logic        stall,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    output logic        access_fault
);

    localparam int CNT_W = $clog2(TX_DEPTH + 1);

    logic             access_fault_q, access_fault_d;

    logic             w_req, w_in_dmem, w_is_txdata, w_is_status;
    logic             w_legal, w_is_half, w_is_word, w_misaligned;
    logic             w_dmem_acc, w_tx_store, w_fault;
    logic [3:0]       w_mask_raw;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext, w_status;
    logic [2:0]       w_count3;
    logic             w_fifo_full, w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    // ---------------- address / size decode ----------------
    always_comb begin
        w_req       = rd_en | wr_en;
        w_in_dmem   = (addr_E[31:C_DMEM_ADDR_BITS] == '0);
        w_is_txdata = (addr_E == UART_BASE + C_UART_TXDATA_OFS);
        w_is_status = (addr_E == UART_BASE + C_UART_STATUS_OFS);

        w_legal   = 1'b1;
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        case (funct3_E)
            F3_B, F3_BU: ;
            F3_H, F3_HU: w_is_half = 1'b1;
            F3_W:        w_is_word = 1'b1;
            default:     w_legal   = 1'b0;
        endcase

        w_misaligned = (w_is_half & addr_E[0]) | (w_is_word & (addr_E[1:0] != 2'b00));
        w_dmem_acc   = w_req & w_in_dmem & w_legal & ~w_misaligned;
        w_tx_store   = wr_en & w_is_txdata & (funct3_E == F3_B);

        // Any TXDATA store other than a byte counts as a fault as well.
        w_fault = w_req & ( ~(w_in_dmem | w_is_txdata | w_is_status)
                          | ~w_legal
                          | w_misaligned
                          | (wr_en & w_is_txdata & (funct3_E != F3_B)) );
    end

    // ---------------- data memory interface ----------------
    always_comb begin
        addrL_LSU      = {24'b0, addr_E[9:2]};
        addrS_LSU      = {24'b0, addr_E[9:2]};
        Data_Memory_on = w_dmem_acc;
        cs_E           = ~w_dmem_acc;
        wr_E           = w_dmem_acc & wr_en;

        if (w_is_word) begin
            store      = rs2_E;
            w_mask_raw = 4'b1111;
        end else if (w_is_half) begin
            store      = {2{rs2_E[15:0]}};
            w_mask_raw = addr_E[1] ? 4'b1100 : 4'b0011;
        end else begin
            store      = {4{rs2_E[7:0]}};
            w_mask_raw = 4'b0001 << addr_E[1:0];
        end
        mask = (w_dmem_acc & wr_en) ? w_mask_raw : 4'b0000;
    end

    // ---------------- load path ----------------
    always_comb begin
        case (addr_E[1:0])
            2'b00:   w_byte = data_rd[7:0];
            2'b01:   w_byte = data_rd[15:8];
            2'b10:   w_byte = data_rd[23:16];
            default: w_byte = data_rd[31:24];
        endcase
        w_half = addr_E[1] ? data_rd[31:16] : data_rd[15:0];

        case (funct3_E)
            F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
            F3_BU:   w_ext = {24'b0, w_byte};
            F3_H:    w_ext = {{16{w_half[15]}}, w_half};
            F3_HU:   w_ext = {16'b0, w_half};
            default: w_ext = data_rd;
        endcase

        w_count3 = 3'(w_fifo_count);
        w_status = '0;
        w_status[C_STAT_COUNT_LSB +: C_STAT_COUNT_W] = w_count3;
        w_status[C_STAT_EMPTY_BIT] = w_fifo_empty;
        w_status[C_STAT_FULL_BIT]  = w_fifo_full;

        if (rd_en & w_dmem_acc) begin
            load_data = w_ext;
        end else if (rd_en & w_is_status & w_legal & ~w_misaligned) begin
            load_data = w_status;
        end else begin
            load_data = '0;
        end
    end

    // ---------------- UART TX FIFO ----------------
    uart_tx_fifo #(
        .TX_DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_tx_store),
        .push_data (rs2_E[7:0]),
        .pop       (uart_tx_valid & uart_tx_ready),
        .head      (uart_tx_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // A pop in the same cycle does not release the stall: the store is
    // retried and lands on the first cycle the FIFO is seen not full.
    always_comb begin
        uart_tx_valid  = ~w_fifo_empty;
        stall          = w_tx_store & w_fifo_full;
        access_fault_d = access_fault_q | w_fault;
        access_fault   = access_fault_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            access_fault_q <= 1'b0;
        end else begin
            access_fault_q <= access_fault_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit: directed scenarios plus
//            randomized data-memory accesses against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int          TX_DEPTH = 4;
    localparam logic [31:0] UART     = 32'h8000_0000;
    localparam logic [31:0] STATUS   = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_E, rs2_E, data_rd;
    logic [2:0]  funct3_E;
    logic        rd_en, wr_en, uart_tx_ready;
    logic [31:0] addrL_LSU, addrS_LSU, store, load_data;
    logic [3:0]  mask;
    logic        cs_E, wr_E, Data_Memory_on, stall;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, access_fault;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic       fault_m;

    always #5 clk = ~clk;

    load_store_unit #(
        .TX_DEPTH  (TX_DEPTH),
        .UART_BASE (UART)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .addr_E         (addr_E),
        .rs2_E          (rs2_E),
        .funct3_E       (funct3_E),
        .rd_en          (rd_en),
        .wr_en          (wr_en),
        .data_rd        (data_rd),
        .uart_tx_ready  (uart_tx_ready),
        .addrL_LSU      (addrL_LSU),
        .addrS_LSU      (addrS_LSU),
        .store          (store),
        .mask           (mask),
        .cs_E           (cs_E),
        .wr_E           (wr_E),
        .Data_Memory_on (Data_Memory_on),
        .load_data      (load_data),
        .stall          (stall),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_valid  (uart_tx_valid),
        .access_fault   (access_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
        rd_en    = rd;
        wr_en    = wr;
        addr_E   = a;
        rs2_E    = d;
        funct3_E = f3;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3,
                                           input logic [31:0] d);
        int n;
        logic [31:0] v, lim;
        n = m_size(f3);
        v = d >> (8 * a[1:0]);
        if (n == 4) return v;
        lim = (32'd1 << (8 * n)) - 32'd1;
        v   = v & lim;
        if (f3[2] == 1'b0 && v[8*n-1]) v = v | ~lim;
        return v;
    endfunction

    function automatic logic [3:0] m_mask(input logic [31:0] a, input int n);
        logic [7:0] m;
        m = 8'((1 << n) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] d, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_status(input int cnt);
        return 32'((cnt << 2) | ((cnt == 0) ? 2 : 0) | ((cnt == TX_DEPTH) ? 1 : 0));
    endfunction

    initial begin
        reset = 1'b0;
        uart_tx_ready = 1'b0;
        data_rd = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        fault_m = 1'b0;

        // ---------- reset state ----------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(uart_tx_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(access_fault), 32'd0);
        chk("rst_cs", 32'(cs_E), 32'd1);
        chk("rst_mask", 32'(mask), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---------- SH to data memory ----------
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0000_0006, 32'h0000_BEEF, 3'b001);
        #1;
        chk("sh_addrS", addrS_LSU, 32'd1);
        chk("sh_store", store, 32'hBEEF_BEEF);
        chk("sh_mask", 32'(mask), 32'b1100);
        chk("sh_cs", 32'(cs_E), 32'd0);
        chk("sh_wr", 32'(wr_E), 32'd1);
        chk("sh_dmon", 32'(Data_Memory_on), 32'd1);

        // ---------- LB / LBU ----------
        @(negedge clk);
        data_rd = 32'h8011_2233;
        drive(1'b1, 1'b0, 32'h0000_0003, 32'h0, 3'b000);
        #1;
        chk("lb_data", load_data, 32'hFFFF_FF80);
        chk("lb_wr", 32'(wr_E), 32'd0);
        chk("lb_mask", 32'(mask), 32'd0);
        funct3_E = 3'b100;
        #1;
        chk("lbu_data", load_data, 32'h0000_0080);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        chk("no_fault_yet", 32'(access_fault), 32'd0);

        // ---------- TX FIFO fill, stall, pop ----------
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, UART, 32'h41 + 32'(i), 3'b000);
            #1;
            chk("fill_stall", 32'(stall), 32'd0);
            exp_q.push_back(8'(8'h41 + i));
        end
        @(negedge clk);
        drive(1'b1, 1'b0, STATUS, 32'h0, 3'b010);
        #1;
        chk("status_full", load_data, m_status(exp_q.size()));
        chk("fill_valid", 32'(uart_tx_valid), 32'd1);
        chk("fill_head", 32'(uart_tx_data), 32'(exp_q[0]));
        @(negedge clk);
        drive(1'b0, 1'b1, UART, 32'h45, 3'b000);
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        @(negedge clk);
        uart_tx_ready = 1'b1;
        #1;
        chk("pop_cycle_stall", 32'(stall), 32'd1);
        chk("pop_head", 32'(uart_tx_data), 32'h41);
        @(negedge clk);
        uart_tx_ready = 1'b0;
        void'(exp_q.pop_front());
        #1;
        chk("stall_drop", 32'(stall), 32'd0);
        chk("head_after_pop", 32'(uart_tx_data), 32'(exp_q[0]));
        exp_q.push_back(8'h45);
        @(negedge clk);
        drive(1'b1, 1'b0, STATUS, 32'h0, 3'b010);
        #1;
        chk("status_refill", load_data, m_status(exp_q.size()));
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            uart_tx_ready = 1'b1;
            #1;
            chk("drain_valid", 32'(uart_tx_valid), 32'd1);
            chk("drain_data", 32'(uart_tx_data), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
        uart_tx_ready = 1'b0;
        #1;
        chk("drained_valid", 32'(uart_tx_valid), 32'd0);
        drive(1'b1, 1'b0, STATUS, 32'h0, 3'b010);
        #1;
        chk("status_empty", load_data, m_status(0));
        chk("fault_clean", 32'(access_fault), 32'd0);

        // ---------- misaligned LW ----------
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0002, 32'h0, 3'b010);
        data_rd = 32'hDEAD_BEEF;
        #1;
        chk("mis_cs", 32'(cs_E), 32'd1);
        chk("mis_load", load_data, 32'd0);
        chk("mis_fault_pre", 32'(access_fault), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        chk("mis_fault", 32'(access_fault), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("mis_fault_held", 32'(access_fault), 32'd1);

        // ---------- reset mid-transfer ----------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, UART, 32'h60 + 32'(i), 3'b000);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        chk("pre_rst_valid", 32'(uart_tx_valid), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(uart_tx_valid), 32'd0);
        chk("async_rst_fault", 32'(access_fault), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, STATUS, 32'h0, 3'b010);
        #1;
        chk("status_after_rst", load_data, 32'h0000_0002);
        chk("valid_after_rst", 32'(uart_tx_valid), 32'd0);

        // ---------- randomized data-memory accesses ----------
        fault_m = 1'b0;
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a, d, r;
            logic [2:0]  f3;
            logic        isw, ok;
            int          n;
            @(negedge clk);
            #1;
            chk("rnd_fault", 32'(access_fault), 32'(fault_m));
            a  = ($urandom_range(0, 3) == 0) ? 32'h0000_0400 + 32'($urandom_range(0, 32'hFFFF))
                                             : 32'($urandom_range(0, 1023));
            f3 = 3'($urandom_range(0, 7));
            isw = 1'($urandom_range(0, 1));
            d  = $urandom;
            r  = $urandom;
            data_rd = r;
            drive(~isw, isw, a, d, f3);
            #1;
            n  = m_size(f3);
            ok = (a < 32'd1024) && (n != 0) && ((a % 32'(n)) == 0);
            chk("rnd_cs", 32'(cs_E), 32'(!ok));
            chk("rnd_dmon", 32'(Data_Memory_on), 32'(ok));
            chk("rnd_wr", 32'(wr_E), 32'(ok && isw));
            chk("rnd_mask", 32'(mask), (ok && isw) ? 32'(m_mask(a, n)) : 32'd0);
            chk("rnd_load", load_data, (ok && !isw) ? m_load(a, f3, r) : 32'd0);
            chk("rnd_stall", 32'(stall), 32'd0);
            if (ok) begin
                chk("rnd_addrL", addrL_LSU, a >> 2);
                if (isw) chk("rnd_store", store, m_store(d, n));
            end
            if (!ok) fault_m = 1'b1;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        chk("rnd_fault_final", 32'(access_fault), 32'(fault_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
